// File: rtl/rr_arbiter_pkg.sv
// Shared helpers for the round-robin port arbiter.
// Widths stay parametric, so the package carries no payload typedefs.
package rr_arbiter_pkg;

  // Pointer advance past grant g, wrapping at n.
  function automatic int rr_next_ptr(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational rotating-priority grant for one output port.
// Scans a doubled request vector from ptr so the wrap needs no separate pass.
module rr_grant #(
  parameter int N  = 32,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any_grant
);

  logic [2*N-1:0] dbl;

  always_comb begin
    dbl       = {req, req};
    gnt       = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (en && !any_grant && (j >= int'(ptr)) && dbl[j]) begin
        any_grant = 1'b1;
        gnt_idx   = (j < N) ? PW'(j) : PW'(j - N);
      end
    end
    if (any_grant) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// N:M round-robin arbiter from input FIFO heads to RAM-bank write ports.
// One rotating-priority grant per port per cycle, winner registered per port.
module rr_port_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS  = 32,
  parameter int NUM_OUTPUTS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = $clog2(NUM_OUTPUTS),
  localparam int PTR_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  in_val,
  input  logic [NUM_INPUTS-1:0][ID_WIDTH-1:0]    in_id,
  input  logic [NUM_INPUTS-1:0]                  in_valid,
  output logic [NUM_INPUTS-1:0]                  in_ready,
  output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] out_val,
  output logic [NUM_OUTPUTS-1:0][ID_WIDTH-1:0]   out_id,
  output logic [NUM_OUTPUTS-1:0]                 out_valid,
  input  logic [NUM_OUTPUTS-1:0]                 out_ready
);

  // Handshake: a beat moves when valid and ready are both high at a rising
  // edge. in_ready is combinational from in_valid/in_id, so upstream must
  // hold valid/val/id steady until ready and never derive valid from ready.

  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] req;
  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] gnt;
  logic [NUM_OUTPUTS-1:0][PTR_WIDTH-1:0]  ptr;
  logic [NUM_OUTPUTS-1:0][PTR_WIDTH-1:0]  gnt_idx;
  logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] sel_val;
  logic [NUM_OUTPUTS-1:0]                 load_en;
  logic [NUM_OUTPUTS-1:0]                 any_grant;

  // Out-of-range ids match no port and are therefore never granted.
  always_comb begin
    req = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        req[o][i] = in_valid[i] && (int'(in_id[i]) == o);
      end
    end
  end

  assign load_en = ~out_valid | out_ready;

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_port
    rr_grant #(
      .N (NUM_INPUTS),
      .PW(PTR_WIDTH)
    ) u_grant (
      .req      (req[o]),
      .ptr      (ptr[o]),
      .en       (load_en[o] && rst_n),
      .gnt      (gnt[o]),
      .gnt_idx  (gnt_idx[o]),
      .any_grant(any_grant[o])
    );
    assign out_id[o] = ID_WIDTH'(o);
  end

  // Each input targets one port, so OR-ing the per-port one-hots never merges two grants.
  always_comb begin
    in_ready = '0;
    sel_val  = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      in_ready   = in_ready | gnt[o];
      sel_val[o] = in_val[gnt_idx[o]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_val   <= '0;
      ptr       <= '0;
    end else begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        if (load_en[o]) begin
          out_valid[o] <= any_grant[o];
          if (any_grant[o]) begin
            out_val[o] <= sel_val[o];
            ptr[o]     <= PTR_WIDTH'(rr_next_ptr(int'(gnt_idx[o]), NUM_INPUTS));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Bench for rr_port_arbiter: directed phases then randomized traffic, all
// compared against a per-port rotating-priority model and a beat scoreboard.
module tb_rr_port_arbiter;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0][DW-1:0] in_val;
  logic [NI-1:0][IW-1:0] in_id;
  logic [NI-1:0]         in_valid;
  logic [NI-1:0]         in_ready;
  logic [NO-1:0][DW-1:0] out_val;
  logic [NO-1:0][IW-1:0] out_id;
  logic [NO-1:0]         out_valid;
  logic [NO-1:0]         out_ready;

  rr_port_arbiter #(
    .NUM_INPUTS (NI),
    .NUM_OUTPUTS(NO),
    .DATA_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (in_val),
    .in_id    (in_id),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_val  (out_val),
    .out_id   (out_id),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // ---------------- reference model / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  bit          m_valid[NO];
  logic [DW-1:0] m_val[NO];
  int          m_ptr[NO];
  int          grant_of[NO];
  logic [NI-1:0] exp_rdy;
  logic [DW-1:0] exp_q[NO][$];
  int pushed = 0, popped = 0, dropped = 0;
  int refill_mode = 0;  // 0 go idle, 1 same id new data, 2 random
  bit chk_rdy = 0, chk_ov = 0;
  logic [NI-1:0] want_rdy;
  logic [NO-1:0] want_ov;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner for each port is the requester at the smallest forward distance from its pointer.
  function automatic void model_grants();
    int bestd, d;
    exp_rdy = '0;
    for (int o = 0; o < NO; o++) begin
      grant_of[o] = -1;
      if (rst_n && (!m_valid[o] || out_ready[o])) begin
        bestd = NI;
        for (int i = 0; i < NI; i++) begin
          if (in_valid[i] && int'(in_id[i]) == o) begin
            d = (i - m_ptr[o] + NI) % NI;
            if (d < bestd) begin
              bestd = d;
              grant_of[o] = i;
            end
          end
        end
        if (grant_of[o] >= 0) exp_rdy[grant_of[o]] = 1'b1;
      end
    end
  endfunction

  task automatic new_beat(input int i);
    in_valid[i] = 1'b1;
    in_id[i]    = IW'($urandom_range(0, NO - 1));
    in_val[i]   = $urandom;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clk);
    model_grants();
    for (int i = 0; i < NI; i++) begin
      assert (!in_valid[i] || int'(in_id[i]) < NO) else begin
        bad++;
        $display("FAIL in_id_range[%0d]: observed=%0d expected<%0d", i, in_id[i], NO);
      end
    end
    for (int o = 0; o < NO; o++) begin
      check($sformatf("out_valid[%0d]", o), 64'(out_valid[o]), 64'(m_valid[o]));
      if (m_valid[o]) check($sformatf("out_val[%0d]", o), 64'(out_val[o]), 64'(m_val[o]));
      check($sformatf("out_id[%0d]", o), 64'(out_id[o]), 64'(o));
      if (rst_n && out_valid[o] === 1'b1 && out_ready[o]) begin
        if (exp_q[o].size() == 0) begin
          check($sformatf("sb_underflow[%0d]", o), 64'(1), 64'(0));
        end else begin
          e = exp_q[o].pop_front();
          popped++;
          check($sformatf("sb_data[%0d]", o), 64'(out_val[o]), 64'(e));
        end
      end
    end
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (chk_rdy) check("in_ready_directed", 64'(in_ready), 64'(want_rdy));
    if (chk_ov) check("out_valid_directed", 64'(out_valid), 64'(want_ov));
    chk_rdy = 0;
    chk_ov  = 0;
    @(posedge clk);
    #1;
    for (int o = 0; o < NO; o++) begin
      if (!rst_n) begin
        m_valid[o] = 0;
        m_val[o]   = '0;
        m_ptr[o]   = 0;
        dropped   += exp_q[o].size();
        exp_q[o].delete();
      end else if (!m_valid[o] || out_ready[o]) begin
        if (grant_of[o] >= 0) begin
          m_valid[o] = 1;
          m_val[o]   = in_val[grant_of[o]];
          m_ptr[o]   = (grant_of[o] + 1) % NI;
          exp_q[o].push_back(in_val[grant_of[o]]);
          pushed++;
        end else begin
          m_valid[o] = 0;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (exp_rdy[i]) begin
        case (refill_mode)
          0: in_valid[i] = 1'b0;
          1: in_val[i] = $urandom;
          default: if ($urandom_range(0, 1) == 1) new_beat(i); else in_valid[i] = 1'b0;
        endcase
      end else if (refill_mode == 2 && !in_valid[i] && $urandom_range(0, 2) == 0) begin
        new_beat(i);
      end
    end
  endtask

  task automatic expect_rdy(input logic [NI-1:0] r);
    want_rdy = r;
    chk_rdy  = 1;
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int o = 0; o < NO; o++) begin
      m_valid[o] = 0;
      m_val[o]   = '0;
      m_ptr[o]   = 0;
    end
    in_valid  = '1;
    for (int i = 0; i < NI; i++) begin
      in_id[i]  = IW'(i);
      in_val[i] = $urandom;
    end
    out_ready = '1;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;

    // reset held with every input valid
    for (int k = 0; k < 3; k++) tick();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_val", 64'(out_val), 64'(0));

    rst_n    = 1'b1;
    in_valid = '0;
    tick();

    // contention on port 2 from inputs 0,1,3
    refill_mode = 1;
    in_valid = 4'b1011;
    for (int i = 0; i < NI; i++) begin
      in_id[i]  = IW'(2);
      in_val[i] = $urandom;
    end
    for (int k = 0; k < 6; k++) begin
      want_ov = (k == 0) ? 4'b0000 : 4'b0100;
      chk_ov  = 1;
      case (k % 3)
        0: expect_rdy(4'b0001);
        1: expect_rdy(4'b0010);
        default: expect_rdy(4'b1000);
      endcase
    end
    refill_mode = 0;
    for (int k = 0; k < 4; k++) tick();

    // all four ports loaded in the same cycle
    in_valid = 4'b1111;
    for (int i = 0; i < NI; i++) begin
      in_id[i]  = IW'(i);
      in_val[i] = $urandom;
    end
    expect_rdy(4'b1111);
    want_ov = 4'b1111;
    chk_ov  = 1;
    tick();

    // stall port 1 with requesters 0 and 2 (pointer sits at 2)
    out_ready = 4'b1101;
    in_valid  = 4'b0101;
    in_id[0]  = IW'(1);
    in_id[2]  = IW'(1);
    in_val[0] = $urandom;
    in_val[2] = $urandom;
    expect_rdy(4'b0100);
    for (int k = 0; k < 5; k++) begin
      want_ov = 4'b0010;
      chk_ov  = 1;
      expect_rdy(4'b0000);
    end
    out_ready = '1;
    expect_rdy(4'b0001);
    expect_rdy(4'b0000);

    // pointer wrap on port 0: move ptr to 3, then request only index 0
    in_valid  = 4'b0100;
    in_id[2]  = IW'(0);
    in_val[2] = $urandom;
    expect_rdy(4'b0100);
    in_valid  = 4'b0001;
    in_id[0]  = IW'(0);
    in_val[0] = $urandom;
    expect_rdy(4'b0001);
    in_valid  = 4'b0011;
    in_id[0]  = IW'(0);
    in_id[1]  = IW'(0);
    in_val[0] = $urandom;
    in_val[1] = $urandom;
    expect_rdy(4'b0010);
    expect_rdy(4'b0001);
    tick();

    // randomized traffic with a reset pulse mid-stream
    refill_mode = 2;
    for (int k = 0; k < 400; k++) begin
      out_ready = NO'($urandom_range(0, (1 << NO) - 1));
      rst_n = (k == 200) ? 1'b0 : 1'b1;
      if (k == 201) begin
        want_ov = '0;
        chk_ov  = 1;
      end
      tick();
    end

    // drain and account for every handshaken beat
    refill_mode = 0;
    out_ready   = '1;
    for (int k = 0; k < 12; k++) tick();
    for (int o = 0; o < NO; o++) begin
      check($sformatf("sb_left[%0d]", o), 64'(exp_q[o].size()), 64'(0));
    end
    check("sb_conservation", 64'(popped + dropped), 64'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
